// File: rtl/key_conditioner_if.sv
// Board-side bundle for the key/switch conditioner: raw pins in, conditioned
// levels, pulses and the switch snapshot out.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4,
  parameter int SW_WIDTH = 10
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [SW_WIDTH-1:0] sw_raw;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] key_press_pulse;
  logic [NUM_KEYS-1:0] key_release_pulse;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] sw_captured;
  logic                capture_valid;

  // Board / stimulus side drives the raw pins and consumes conditioned values
  modport master (
    output key_raw,
    output sw_raw,
    input  key_pressed,
    input  key_press_pulse,
    input  key_release_pulse,
    input  sw_sync,
    input  sw_captured,
    input  capture_valid
  );

  // Conditioner side
  modport slave (
    input  key_raw,
    input  sw_raw,
    output key_pressed,
    output key_press_pulse,
    output key_release_pulse,
    output sw_sync,
    output sw_captured,
    output capture_valid
  );
endinterface

// File: rtl/key_conditioner.sv
// Key/switch front end: synchronises the active-low buttons, debounces each one
// with its own four-state FSM, emits one-cycle press/release pulses, and
// snapshots the synchronised switches when the capture key is accepted.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int CAPTURE_KEY     = 1
) (
  input logic              clock,
  input logic              reset,
  key_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    UP           = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } keyState_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_KEYS-1:0]  keyMeta_q;
  logic [NUM_KEYS-1:0]  keySync_q;
  logic [SW_WIDTH-1:0]  swMeta_q;
  logic [SW_WIDTH-1:0]  swSync_q;

  keyState_t            state_q [NUM_KEYS];
  keyState_t            state_d [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0]  pressPulse_q;
  logic [NUM_KEYS-1:0]  pressPulse_d;
  logic [NUM_KEYS-1:0]  releasePulse_q;
  logic [NUM_KEYS-1:0]  releasePulse_d;
  logic [NUM_KEYS-1:0]  keyPressed;

  logic [SW_WIDTH-1:0]  swCaptured_q;
  logic                 captureValid_q;

  // Two-flop synchronisers; key stages preset to "released" so reset never looks like a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keyMeta_q <= '1;
      keySync_q <= '1;
      swMeta_q  <= '0;
      swSync_q  <= '0;
    end else begin
      keyMeta_q <= bus.key_raw;
      keySync_q <= keyMeta_q;
      swMeta_q  <= bus.sw_raw;
      swSync_q  <= swMeta_q;
    end
  end

  // Debounce state, counters and the registered pulses that coincide with state changes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= UP;
        cnt_q[i]   <= '0;
      end
      pressPulse_q   <= '0;
      releasePulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pressPulse_q   <= pressPulse_d;
      releasePulse_q <= releasePulse_d;
    end
  end

  // Next-state logic: a level change must hold for DEBOUNCE_CYCLES samples; any bounce restarts
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        UP: begin
          cnt_d[i] = '0;
          if (!keySync_q[i]) state_d[i] = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (keySync_q[i]) begin
            state_d[i] = UP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        DOWN: begin
          cnt_d[i] = '0;
          if (keySync_q[i]) state_d[i] = RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (!keySync_q[i]) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = UP;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = UP;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode: debounced level from state, pulses armed on accepted transitions
  always_comb begin
    keyPressed     = '0;
    pressPulse_d   = '0;
    releasePulse_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      keyPressed[i]     = (state_q[i] == DOWN) || (state_q[i] == RELEASE_WAIT);
      pressPulse_d[i]   = (state_q[i] == PRESS_WAIT)   && (state_d[i] == DOWN);
      releasePulse_d[i] = (state_q[i] == RELEASE_WAIT) && (state_d[i] == UP);
    end
  end

  // Switch snapshot taken on the same edge that raises the capture key's press pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      swCaptured_q   <= '0;
      captureValid_q <= 1'b0;
    end else if (pressPulse_d[CAPTURE_KEY]) begin
      swCaptured_q   <= swSync_q;
      captureValid_q <= 1'b1;
    end
  end

  assign bus.key_pressed       = keyPressed;
  assign bus.key_press_pulse   = pressPulse_q;
  assign bus.key_release_pulse = releasePulse_q;
  assign bus.sw_sync           = swSync_q;
  assign bus.sw_captured       = swCaptured_q;
  assign bus.capture_valid     = captureValid_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with a short debounce period; expected pulses are
// queued when keys are driven and matched by a negedge monitor.
module tb_key_conditioner;

  localparam int NK  = 4;
  localparam int SWW = 10;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  typedef struct {
    int             cycle;
    bit             isRelease;
    int             key;
    bit             checkSw;
    logic [SWW-1:0] sw;
  } expEvent_t;

  logic      clock;
  logic      reset;
  int        edgeCount;
  int        checks;
  int        failures;
  expEvent_t sbQueue[$];

  key_conditioner_if #(.NUM_KEYS(NK), .SW_WIDTH(SWW)) bus ();

  key_conditioner #(
    .NUM_KEYS(NK),
    .SW_WIDTH(SWW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(3),
    .CAPTURE_KEY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to time-stamp expected pulses
  initial edgeCount = 0;
  always @(posedge clock) edgeCount = edgeCount + 1;

  // Scoreboard monitor: every observed pulse must match the queue front
  always @(negedge clock) begin
    expEvent_t e;
    logic      p;
    while (sbQueue.size() > 0 && sbQueue[0].cycle < edgeCount) begin
      e = sbQueue.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missed_pulse key=%0d release=%0d expected_edge=%0d now=%0d",
               e.key, e.isRelease, e.cycle, edgeCount);
    end
    for (int k = 0; k < NK; k++) begin
      for (int r = 0; r < 2; r++) begin
        p = (r == 1) ? bus.key_release_pulse[k] : bus.key_press_pulse[k];
        if (p) begin
          checks++;
          if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_pulse key=%0d release=%0d edge=%0d expected none",
                     k, r, edgeCount);
          end else begin
            e = sbQueue.pop_front();
            if (e.key !== k || e.isRelease !== (r == 1) || e.cycle !== edgeCount) begin
              failures++;
              $display("[TB] FAIL pulse_match got key=%0d rel=%0d edge=%0d expected key=%0d rel=%0d edge=%0d",
                       k, r, edgeCount, e.key, e.isRelease, e.cycle);
            end
            checks++;
            if (bus.key_pressed[k] !== (r == 0)) begin
              failures++;
              $display("[TB] FAIL level_at_pulse key=%0d got=%0b expected=%0b",
                       k, bus.key_pressed[k], (r == 0));
            end
            if (e.checkSw) begin
              checks++;
              if (bus.sw_captured !== e.sw || bus.capture_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL capture_at_pulse got sw=%h valid=%b expected sw=%h valid=1",
                         bus.sw_captured, bus.capture_valid, e.sw);
              end
            end
          end
        end
      end
    end
  end

  // Push an expected pulse for a level change driven at the current negedge
  task automatic applyStimulus(input int key, input bit rel, input bit chkSw,
                               input logic [SWW-1:0] sw);
    expEvent_t e;
    e.cycle     = edgeCount + LAT;
    e.isRelease = rel;
    e.key       = key;
    e.checkSw   = chkSw;
    e.sw        = sw;
    sbQueue.push_back(e);
  endtask

  // Reset state: all outputs zero during and just after reset
  task automatic test_reset();
    reset       = 1'b1;
    bus.key_raw = '1;
    bus.sw_raw  = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.key_pressed, bus.key_press_pulse, bus.key_release_pulse,
         bus.sw_sync, bus.sw_captured, bus.capture_valid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h expected=0",
               {bus.key_pressed, bus.key_press_pulse, bus.key_release_pulse,
                bus.sw_sync, bus.sw_captured, bus.capture_valid});
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b0000 || bus.capture_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got pressed=%b valid=%b expected pressed=0000 valid=0",
               bus.key_pressed, bus.capture_valid);
    end
  endtask

  // Clean press on key 0
  task automatic test_clean_press();
    bus.key_raw[0] = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0);
    repeat (20) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL clean_press_level got=%b expected=0001", bus.key_pressed);
    end
    checks++;
    if (sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL clean_press_queue got=%0d expected=0", sbQueue.size());
    end
  endtask

  // Release of key 0
  task automatic test_release();
    bus.key_raw[0] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, '0);
    repeat (10) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL release_level got=%b expected=0000", bus.key_pressed);
    end
    checks++;
    if (sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL release_queue got=%0d expected=0", sbQueue.size());
    end
  endtask

  // Bouncing key 2 never long enough to be accepted
  task automatic test_bounce();
    logic [5:0] pattern;
    pattern = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      bus.key_raw[2] = pattern[i];
      @(negedge clock);
    end
    bus.key_raw[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.key_pressed[2] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bounce_level cycle=%0d got=%b expected=0", i, bus.key_pressed[2]);
      end
      @(negedge clock);
    end
  endtask

  // Switch snapshot on key 1 press, then held across a switch change
  task automatic test_capture();
    checks++;
    if (bus.capture_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL capture_valid_initial got=%b expected=0", bus.capture_valid);
    end
    bus.sw_raw = 10'h0A5;
    repeat (3) @(negedge clock);
    bus.key_raw[1] = 1'b0;
    applyStimulus(1, 1'b0, 1'b1, 10'h0A5);
    repeat (10) @(negedge clock);
    bus.sw_raw = 10'h3FF;
    repeat (5) @(negedge clock);
    checks++;
    if (bus.sw_captured !== 10'h0A5 || bus.capture_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL capture_hold got sw=%h valid=%b expected sw=0a5 valid=1",
               bus.sw_captured, bus.capture_valid);
    end
    checks++;
    if (bus.sw_sync !== 10'h3FF) begin
      failures++;
      $display("[TB] FAIL sw_sync got=%h expected=3ff", bus.sw_sync);
    end
    bus.key_raw[1] = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, '0);
    repeat (10) @(negedge clock);
    checks++;
    if (sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL capture_queue got=%0d expected=0", sbQueue.size());
    end
  endtask

  // Keys 0 and 3 pressed and released back to back on the same edges
  task automatic test_back_to_back();
    bus.key_raw[0] = 1'b0;
    bus.key_raw[3] = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0);
    applyStimulus(3, 1'b0, 1'b0, '0);
    repeat (12) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL simultaneous_level got=%b expected=1001", bus.key_pressed);
    end
    bus.key_raw[0] = 1'b1;
    bus.key_raw[3] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, '0);
    applyStimulus(3, 1'b1, 1'b0, '0);
    repeat (12) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b0000 || sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL simultaneous_release got pressed=%b queue=%0d expected pressed=0000 queue=0",
               bus.key_pressed, sbQueue.size());
    end
  endtask

  // Reset asserted mid-debounce with key 0 held, then released while still held
  task automatic test_reset_held();
    bus.key_raw[0] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.key_pressed, bus.key_press_pulse, bus.key_release_pulse,
           bus.sw_sync, bus.sw_captured, bus.capture_valid} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_held_outputs cycle=%0d got=%h expected=0", i,
                 {bus.key_pressed, bus.key_press_pulse, bus.key_release_pulse,
                  bus.sw_sync, bus.sw_captured, bus.capture_valid});
      end
    end
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0);
    repeat (LAT - 1) @(negedge clock);
    checks++;
    if (bus.key_pressed[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held_early got=%b expected=0", bus.key_pressed[0]);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (bus.key_pressed !== 4'b0001 || sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL reset_held_press got pressed=%b queue=%0d expected pressed=0001 queue=0",
               bus.key_pressed, sbQueue.size());
    end
    bus.key_raw[0] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, '0);
    repeat (10) @(negedge clock);
  endtask

  // Sequencer
  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.key_raw = '1;
    bus.sw_raw  = '0;
    @(negedge clock);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_capture();
    test_back_to_back();
    test_reset_held();
    checks++;
    if (sbQueue.size() !== 0) begin
      failures++;
      $display("[TB] FAIL final_queue got=%0d expected=0", sbQueue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
